hex_scan_ctrl: RTL and testbench



---
 rtl/hex_scan_ctrl_pkg.sv | 32 +++
 rtl/hex_scan_ctrl_if.sv | 19 +
 rtl/hex_scan_ctrl_seg_decode.sv | 28 ++
 rtl/hex_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types, register map and helpers for the multiplexed hex digit scanner.
package hex_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      BLANK = 2'd2
   } scan_state_e;

   localparam logic [1:0] ADDR_DIGITS = 2'd0;
   localparam logic [1:0] ADDR_BLANK  = 2'd1;
   localparam logic [1:0] ADDR_DP     = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_COMMIT = 1;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
         else       r[8*b +: 8] = old_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Avalon-MM slave bus bundle for the hex scan controller.
interface hex_scan_ctrl_if;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;

   modport master (
      output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/hex_scan_ctrl_seg_decode.sv
// Nibble to seven-segment (gfedcba, active-low) decoder, shared by all digits.
module hex_seg_decode (
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_n_o
);
   // glyph lookup
   always_comb begin
      case (nibble_i)
         4'h0:    seg_n_o = 7'h40;
         4'h1:    seg_n_o = 7'h79;
         4'h2:    seg_n_o = 7'h24;
         4'h3:    seg_n_o = 7'h30;
         4'h4:    seg_n_o = 7'h19;
         4'h5:    seg_n_o = 7'h12;
         4'h6:    seg_n_o = 7'h02;
         4'h7:    seg_n_o = 7'h78;
         4'h8:    seg_n_o = 7'h00;
         4'h9:    seg_n_o = 7'h10;
         4'hA:    seg_n_o = 7'h08;
         4'hB:    seg_n_o = 7'h03;
         4'hC:    seg_n_o = 7'h46;
         4'hD:    seg_n_o = 7'h21;
         4'hE:    seg_n_o = 7'h06;
         4'hF:    seg_n_o = 7'h0E;
         default: seg_n_o = 7'h7F;
      endcase
   end
endmodule

// File: rtl/hex_scan_ctrl.sv
// Scan controller: shadow/active digit state, frame-boundary commit, and a
// DRIVE/BLANK slot sequencer time-sharing one segment decoder.
module hex_scan_ctrl
   import hex_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 500
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   hex_scan_ctrl_if.slave        avs,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [NUM_DIGITS-1:0] dig_n,
   output logic                  frame_done
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam bit               HAS_GAP    = (BLANK_CYC > 0);

   logic [31:0]           shadow_dig_q, act_dig_q, readdata_q, rd_mux_s;
   logic [7:0]            shadow_blank_q, shadow_dp_q, act_blank_q, act_dp_q;
   logic                  enable_q, pending_q;
   scan_state_e           state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]      idx_q, idx_nxt_s;
   logic [6:0]            seg_n_q, seg_dec_s;
   logic                  dp_n_q, frame_done_q;
   logic [NUM_DIGITS-1:0] dig_n_q;
   logic                  commit_wr_s, slot_end_s, last_s, wrap_s, boundary_s, show_s;
   logic [4:0]            nib_base_s;
   logic [2:0]            bit_sel_s;
   logic [3:0]            nib_sel_s;

   assign commit_wr_s = avs.avs_write && (avs.avs_address == ADDR_CTRL) &&
                        avs.avs_byteenable[0] && avs.avs_writedata[CTRL_COMMIT];
   assign slot_end_s  = ((state_q == DRIVE) && (cnt_q == DRIVE_LAST) && !HAS_GAP) ||
                        ((state_q == BLANK) && (cnt_q == BLANK_LAST));
   assign last_s      = (idx_q == IDX_LAST);
   assign wrap_s      = enable_q && slot_end_s && last_s;
   assign boundary_s  = (state_q == IDLE) || (slot_end_s && last_s);
   assign idx_nxt_s   = last_s ? {IDX_W{1'b0}} : idx_q + IDX_W'(1'b1);

   // register readback mux
   always_comb begin
      case (avs.avs_address)
         ADDR_DIGITS: rd_mux_s = shadow_dig_q;
         ADDR_BLANK:  rd_mux_s = {24'h0, shadow_blank_q};
         ADDR_DP:     rd_mux_s = {24'h0, shadow_dp_q};
         ADDR_CTRL:   rd_mux_s = {30'h0, pending_q, enable_q};
         default:     rd_mux_s = 32'h0;
      endcase
   end

   // bus-visible shadow/control registers and the boundary copy into active state
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         shadow_dig_q   <= 32'h0;
         shadow_blank_q <= 8'h0;
         shadow_dp_q    <= 8'h0;
         act_dig_q      <= 32'h0;
         act_blank_q    <= 8'h0;
         act_dp_q       <= 8'h0;
         enable_q       <= 1'b0;
         pending_q      <= 1'b0;
         readdata_q     <= 32'h0;
      end else begin
         if (avs.avs_write && (avs.avs_address == ADDR_DIGITS))
            shadow_dig_q <= be_merge(shadow_dig_q, avs.avs_writedata, avs.avs_byteenable);
         if (avs.avs_write && (avs.avs_address == ADDR_BLANK) && avs.avs_byteenable[0])
            shadow_blank_q <= avs.avs_writedata[7:0];
         if (avs.avs_write && (avs.avs_address == ADDR_DP) && avs.avs_byteenable[0])
            shadow_dp_q <= avs.avs_writedata[7:0];
         if (avs.avs_write && (avs.avs_address == ADDR_CTRL) && avs.avs_byteenable[0])
            enable_q <= avs.avs_writedata[CTRL_ENABLE];
         // the copy samples pre-write shadow values; a commit on the boundary waits a frame
         if (boundary_s && pending_q) begin
            act_dig_q   <= shadow_dig_q;
            act_blank_q <= shadow_blank_q;
            act_dp_q    <= shadow_dp_q;
         end
         pending_q  <= (pending_q && !boundary_s) || commit_wr_s;
         readdata_q <= avs.avs_read ? rd_mux_s : 32'h0;
      end
   end

   // current digit's active nibble and blank selection
   always_comb begin
      nib_base_s = 5'({idx_q, 2'b00});
      bit_sel_s  = 3'(idx_q);
      nib_sel_s  = act_dig_q[nib_base_s +: 4];
      show_s     = enable_q && (state_q == DRIVE) && !act_blank_q[bit_sel_s];
   end

   hex_seg_decode u_dec (
      .nibble_i (nib_sel_s),
      .seg_n_o  (seg_dec_s)
   );

   // slot sequencer with registered display outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         seg_n_q      <= SEG_OFF;
         dp_n_q       <= 1'b1;
         dig_n_q      <= {NUM_DIGITS{1'b1}};
         frame_done_q <= 1'b0;
      end else begin
         seg_n_q      <= show_s ? seg_dec_s : SEG_OFF;
         dp_n_q       <= show_s ? ~act_dp_q[bit_sel_s] : 1'b1;
         dig_n_q      <= show_s ? ~(NUM_DIGITS'(1'b1) << idx_q) : {NUM_DIGITS{1'b1}};
         frame_done_q <= wrap_s;
         if (!enable_q) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= DRIVE;
                  cnt_q   <= {CNT_W{1'b0}};
                  idx_q   <= {IDX_W{1'b0}};
               end
               DRIVE: begin
                  if (cnt_q == DRIVE_LAST) begin
                     cnt_q <= {CNT_W{1'b0}};
                     if (HAS_GAP) begin
                        state_q <= BLANK;
                     end else begin
                        state_q <= DRIVE;
                        idx_q   <= idx_nxt_s;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1'b1);
                  end
               end
               BLANK: begin
                  if (cnt_q == BLANK_LAST) begin
                     cnt_q   <= {CNT_W{1'b0}};
                     state_q <= DRIVE;
                     idx_q   <= idx_nxt_s;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1'b1);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= {CNT_W{1'b0}};
                  idx_q   <= {IDX_W{1'b0}};
               end
            endcase
         end
      end
   end

   assign seg_n            = seg_n_q;
   assign dp_n             = dp_n_q;
   assign dig_n            = dig_n_q;
   assign frame_done       = frame_done_q;
   assign avs.avs_readdata = readdata_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected digit runs and read data; monitors pop and compare.
module tb_hex_scan_ctrl;
   localparam int ND = 8;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct {
      logic [7:0] dig;
      logic [6:0] seg;
      logic       dp;
      int         len;
      int         gap;
   } run_t;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic [ND-1:0] dig_n;
   logic          frame_done;

   hex_scan_ctrl_if bus();

   hex_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .avs        (bus),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .dig_n      (dig_n),
      .frame_done (frame_done)
   );

   always #5 Clk = ~Clk;

   run_t        run_q[$];
   logic [31:0] rd_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_fd = -1;
   int          prev_start = -1;
   bit          mon_en = 1'b0;
   bit          in_run = 1'b0;
   logic        rd_d = 1'b0;
   logic [7:0]  run_dig;
   logic [6:0]  run_seg;
   logic        run_dp;
   int          run_len, run_gap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic push_frame(input logic [31:0] nib, input logic [7:0] blank, input logic [7:0] dp,
                             input int first_gap, input int last_d, input int last_len);
      run_t r;
      int   slots;
      bit   first;
      slots = 0;
      first = 1'b1;
      for (int d = 0; d <= last_d; d++) begin
         if (!blank[d]) begin
            r.dig = ~(8'h01 << d);
            r.seg = SEG_TAB[nib[4*d +: 4]];
            r.dp  = ~dp[d];
            r.len = (d == last_d) ? last_len : SD - BC;
            r.gap = first ? first_gap : slots * SD;
            run_q.push_back(r);
            first = 1'b0;
            slots = 0;
         end
         slots++;
      end
   endtask

   task automatic finish_run();
      run_t e;
      in_run = 1'b0;
      if (run_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_run: got dig_n=%0h, expected no run", run_dig);
      end else begin
         e = run_q.pop_front();
         chk("run_dig_n", 32'(run_dig), 32'(e.dig));
         chk("run_seg_n", 32'(run_seg), 32'(e.seg));
         chk("run_dp_n",  32'(run_dp),  32'(e.dp));
         chk("run_len",   32'(run_len), 32'(e.len));
         if (e.gap != 0) chk("run_gap", 32'(run_gap), 32'(e.gap));
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      @(posedge Clk); #1;
      bus.avs_address    = a;
      bus.avs_writedata  = d;
      bus.avs_byteenable = be;
      bus.avs_write      = 1'b1;
      @(posedge Clk); #1;
      bus.avs_write      = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
      @(posedge Clk); #1;
      bus.avs_address = a;
      bus.avs_read    = 1'b1;
      rd_q.push_back(exp);
      @(posedge Clk); #1;
      bus.avs_read    = 1'b0;
   endtask

   task automatic wait_digit(input int d);
      int   n;
      logic [7:0] tgt, prev;
      tgt  = ~(8'h01 << d);
      prev = dig_n;
      n    = 0;
      forever begin
         @(negedge Clk);
         n++;
         if (dig_n == tgt && prev != tgt) break;
         if (n > 300) begin
            timeout("wait_digit");
            break;
         end
         prev = dig_n;
      end
   endtask

   task automatic wait_fd();
      int n;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (frame_done !== 1'b1 && n < 200);
      if (frame_done !== 1'b1) timeout("wait_frame_done");
   endtask

   always @(posedge Clk) cyc <= cyc + 1;
   always @(posedge Clk) rd_d <= bus.avs_read;

   // read-data monitor
   always @(negedge Clk) begin
      if (rd_d) begin
         if (rd_q.size() == 0) timeout("readdata_queue");
         else chk("readdata", bus.avs_readdata, rd_q.pop_front());
      end
   end

   // display run monitor
   always @(negedge Clk) begin
      if (mon_en) begin
         if (dig_n == 8'hFF) begin
            chk("off_outputs", {24'h0, seg_n, dp_n}, {24'h0, 7'h7F, 1'b1});
            if (in_run) finish_run();
         end else begin
            if (in_run && (dig_n != run_dig || seg_n != run_seg || dp_n != run_dp)) finish_run();
            if (!in_run) begin
               in_run     = 1'b1;
               run_dig    = dig_n;
               run_seg    = seg_n;
               run_dp     = dp_n;
               run_len    = 1;
               run_gap    = (prev_start >= 0) ? cyc - prev_start : 0;
               prev_start = cyc;
            end else begin
               run_len++;
            end
         end
      end else begin
         in_run = 1'b0;
      end
   end

   // frame period monitor
   always @(negedge Clk) begin
      if (mon_en && frame_done === 1'b1) begin
         if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'd64);
         last_fd = cyc;
      end
   end

   initial begin
      int lat;
      int n;
      bus.avs_address    = 2'd0;
      bus.avs_read       = 1'b0;
      bus.avs_write      = 1'b0;
      bus.avs_byteenable = 4'h0;
      bus.avs_writedata  = 32'h0;

      repeat (3) @(negedge Clk);
      chk("rst_seg_n", 32'(seg_n), 32'h7F);
      chk("rst_dig_n", 32'(dig_n), 32'hFF);
      chk("rst_dp_n", 32'(dp_n), 32'h1);
      chk("rst_readdata", bus.avs_readdata, 32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      mon_en  = 1'b1;
      bus_read(2'd3, 32'h0);

      // basic scan, then tearing guard inside the first frame
      push_frame(32'h8765_43A0, 8'h00, 8'h00, 0, 7, 6);
      push_frame(32'h5555_5555, 8'h00, 8'h00, 8, 7, 6);
      bus_write(2'd0, 32'h8765_43A0, 4'hF);
      bus_write(2'd3, 32'h0000_0002, 4'hF);
      bus_write(2'd3, 32'h0000_0001, 4'hF);
      wait_digit(3);
      bus_write(2'd0, 32'h5555_5555, 4'hF);
      bus_read(2'd0, 32'h5555_5555);
      wait_digit(5);
      bus_write(2'd3, 32'h0000_0003, 4'hF);
      bus_read(2'd3, 32'h0000_0003);
      wait_fd();
      bus_read(2'd3, 32'h0000_0001);

      // blank and decimal point
      push_frame(32'h5555_5555, 8'h02, 8'h01, 8, 7, 6);
      bus_write(2'd1, 32'h0000_0002, 4'h1);
      bus_write(2'd2, 32'h0000_0001, 4'h1);
      bus_write(2'd3, 32'h0000_0003, 4'hF);
      bus_read(2'd1, 32'h0000_0002);
      wait_fd();

      // disable in the middle of digit 4
      push_frame(32'h5555_5555, 8'h02, 8'h01, 8, 4, 3);
      wait_fd();
      wait_digit(4);
      bus_write(2'd3, 32'h0000_0000, 4'hF);
      last_fd = -1;
      repeat (4) @(posedge Clk);

      // byte enables while idle, no commit
      bus_write(2'd0, 32'hAAAA_AAFF, 4'b0001);
      bus_read(2'd0, 32'h5555_55FF);
      bus_write(2'd1, 32'h0000_0000, 4'h1);
      bus_write(2'd2, 32'h0000_0000, 4'h1);
      bus_read(2'd1, 32'h0000_0000);

      // re-enable, then a commit landing exactly on the frame boundary
      push_frame(32'h5555_5555, 8'h02, 8'h01, 0, 7, 6);
      push_frame(32'h5555_5555, 8'h02, 8'h01, 8, 7, 6);
      push_frame(32'h5555_55FF, 8'h00, 8'h00, 8, 7, 6);
      bus_write(2'd3, 32'h0000_0001, 4'hF);
      lat = 0;
      while (dig_n == 8'hFF && lat < 20) begin
         @(posedge Clk); #1;
         lat++;
      end
      chk("reenable_latency", 32'(lat), 32'd2);
      wait_digit(7);
      repeat (5) @(posedge Clk);
      bus_write(2'd3, 32'h0000_0003, 4'hF);
      bus_read(2'd3, 32'h0000_0003);
      wait_fd();
      bus_read(2'd3, 32'h0000_0001);

      n = 0;
      while (run_q.size() != 0 && n < 400) begin
         @(negedge Clk);
         n++;
      end
      if (run_q.size() != 0) timeout("run_queue_drain");
      mon_en = 1'b0;
      bus_write(2'd3, 32'h0000_0000, 4'hF);
      repeat (4) @(posedge Clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
